// File: rtl/sample_div_seq_13s_8u.sv
// Sequential restoring divider: signed dividend / unsigned divisor.
// One quotient bit per clock. Quotient and remainder truncate toward zero.
//
// state  | meaning
// IDLE   | waiting for ap_start; operands latched on accept
// CALC   | one restoring step per cycle, MSB first, DIVIDEND_W cycles
// FIX    | apply dividend sign, handle divide-by-zero, register results
// DONE   | ap_done/ap_ready pulse for one cycle
module sample_div_seq_13s_8u #(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          DIVIDEND_W = 13,
  parameter int          DIVISOR_W  = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ap_start,
  input  logic signed [DIVIDEND_W-1:0] din0,
  input  logic        [DIVISOR_W-1:0]  din1,
  output logic                         ap_idle,
  output logic                         ap_done,
  output logic                         ap_ready,
  output logic signed [DIVIDEND_W-1:0] quot,
  output logic signed [DIVISOR_W:0]    rem,
  output logic                         div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DIVIDEND_W - 1);

  // ID is an instance tag only; it selects nothing in the datapath.
  if (ID == 32'd0) begin : g_untagged
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_load;
  logic w_calc;
  logic w_fix;

  logic                         r_sign;
  logic        [DIVIDEND_W-1:0] r_dq;
  logic        [DIVISOR_W-1:0]  r_dvs;
  logic        [DIVISOR_W:0]    r_pr;
  logic        [CNT_W-1:0]      r_cnt;
  logic signed [DIVIDEND_W-1:0] r_quot;
  logic signed [DIVISOR_W:0]    r_rem;
  logic                         r_dbz;

  logic [DIVIDEND_W-1:0] w_abs;
  logic [DIVISOR_W:0]    w_shift;
  logic                  w_ge;
  logic [DIVISOR_W:0]    w_pr_nxt;
  logic                  w_dvs_zero;

  // -4096 maps to 13'h1000, which is the correct unsigned magnitude.
  assign w_abs      = din0[DIVIDEND_W-1] ? (~din0 + 1'b1) : din0;
  assign w_shift    = {r_pr[DIVISOR_W-1:0], r_dq[DIVIDEND_W-1]};
  assign w_ge       = (w_shift >= {1'b0, r_dvs});
  assign w_pr_nxt   = w_ge ? (w_shift - {1'b0, r_dvs}) : w_shift;
  assign w_dvs_zero = (r_dvs == '0);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ap_idle     = 1'b0;
    ap_done     = 1'b0;
    w_load      = 1'b0;
    w_calc      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          w_load      = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_calc = 1'b1;
        if (r_cnt == LP_LAST) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        ap_done     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign ap_ready = ap_done;

  // r_dq holds the remaining dividend bits; quotient bits enter at the LSB.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_sign <= 1'b0;
      r_dq   <= '0;
      r_dvs  <= '0;
      r_pr   <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      if (w_load) begin
        r_sign <= din0[DIVIDEND_W-1];
        r_dq   <= w_abs;
        r_dvs  <= din1;
        r_pr   <= '0;
        r_cnt  <= '0;
      end
      if (w_calc) begin
        r_pr  <= w_pr_nxt;
        r_dq  <= {r_dq[DIVIDEND_W-2:0], w_ge};
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fix) begin
        r_dbz <= w_dvs_zero;
        if (w_dvs_zero) begin
          r_quot <= '0;
          r_rem  <= '0;
        end else begin
          r_quot <= r_sign ? -r_dq : r_dq;
          r_rem  <= r_sign ? -r_pr : r_pr;
        end
      end
    end
  end

  assign quot        = r_quot;
  assign rem         = r_rem;
  assign div_by_zero = r_dbz;

endmodule
